// File: rtl/axi_wr_sched.sv
// Round-robin AW arbiter that locks one master onto the write port through AW, W..WLAST and B.
// Grant takes one registered cycle; valid/ready paths are combinational passthrough gated by state/sel.
module axi_wr_sched #(
    parameter int N     = 2,
    parameter int LOG_N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s_awvalid,
    output logic [N-1:0]     s_awready,
    input  logic [N-1:0]     s_wvalid,
    input  logic [N-1:0]     s_wlast,
    output logic [N-1:0]     s_wready,
    output logic [N-1:0]     s_bvalid,
    input  logic [N-1:0]     s_bready,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic             m_wvalid,
    output logic             m_wlast,
    input  logic             m_wready,
    input  logic             m_bvalid,
    output logic             m_bready,
    output logic [LOG_N-1:0] sel,
    output logic             busy,
    output logic [8:0]       beat_cnt
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state, state_nxt;
    logic [LOG_N-1:0] ptr, ptr_nxt, sel_nxt, winner, idx;
    logic [8:0]       beat_nxt;
    logic             found;

    // Search starts at ptr and wraps; the first requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = LOG_N'((int'(ptr) + i) % N);
            if (!found && s_awvalid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = ADDR;
                    sel_nxt   = winner;
                    ptr_nxt   = LOG_N'((int'(winner) + 1) % N);
                    beat_nxt  = '0;
                end
            end
            ADDR: begin
                if (m_awvalid && m_awready)
                    state_nxt = DATA;
            end
            DATA: begin
                if (m_wvalid && m_wready) begin
                    if (beat_cnt != 9'd511)
                        beat_nxt = beat_cnt + 9'd1;
                    if (m_wlast)
                        state_nxt = RESP;
                end
            end
            RESP: begin
                if (m_bvalid && m_bready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the channel owned by the current state is opened, and only for sel.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        case (state)
            ADDR: begin
                m_awvalid      = s_awvalid[sel];
                s_awready[sel] = m_awready;
            end
            DATA: begin
                m_wvalid      = s_wvalid[sel];
                m_wlast       = s_wlast[sel];
                s_wready[sel] = m_wready;
            end
            RESP: begin
                s_bvalid[sel] = m_bvalid;
                m_bready      = s_bready[sel];
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            beat_cnt <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_axi_wr_sched.sv
// Bench for axi_wr_sched: bench plays masters and slave, checks every cycle against round-robin rules.
module tb_axi_wr_sched;
    localparam int N     = 4;
    localparam int LOG_N = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic             m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic [LOG_N-1:0] sel;
    logic             busy;
    logic [8:0]       beat_cnt;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;
    int last_sel = 0;
    int last_beat = 0;

    always #5 clk = ~clk;

    axi_wr_sched #(.N(N), .LOG_N(LOG_N)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .sel(sel), .busy(busy), .beat_cnt(beat_cnt)
    );

    function automatic int rr(input int p, input logic [N-1:0] req);
        for (int i = 0; i < N; i++)
            if (req[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic int sat(input int k);
        return (k > 511) ? 511 : k;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string ph, input logic eawv, input logic [N-1:0] eawr,
                           input logic ewv, input logic ewl, input logic [N-1:0] ewr,
                           input logic [N-1:0] ebv, input logic ebr, input int esel,
                           input logic ebusy, input int ebeat);
        chk({ph, " m_awvalid"}, 16'(m_awvalid), 16'(eawv));
        chk({ph, " s_awready"}, 16'(s_awready), 16'(eawr));
        chk({ph, " m_wvalid"},  16'(m_wvalid),  16'(ewv));
        chk({ph, " m_wlast"},   16'(m_wlast),   16'(ewl));
        chk({ph, " s_wready"},  16'(s_wready),  16'(ewr));
        chk({ph, " s_bvalid"},  16'(s_bvalid),  16'(ebv));
        chk({ph, " m_bready"},  16'(m_bready),  16'(ebr));
        chk({ph, " sel"},       16'(sel),       16'(esel));
        chk({ph, " busy"},      16'(busy),      16'(ebusy));
        chk({ph, " beat_cnt"},  16'(beat_cnt),  16'(ebeat));
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    endtask

    // Reset is held with every input active: outputs must stay closed regardless.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_awvalid = '1; s_wvalid = '1; s_wlast = '1; s_bready = '1;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        #1 chk_all("reset", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        ptr_m = 0; last_sel = 0; last_beat = 0;
    endtask

    // One transaction from its IDLE cycle to the B handshake (or a reset at beat abort_at).
    task automatic do_txn(input logic [N-1:0] req, input int beats, input bit bp,
                          input bit early_w, input int abort_at,
                          output int nbusy, output int gsel);
        int   w, k;
        logic hs;
        w = rr(ptr_m, req);
        ptr_m = (w + 1) % N;
        nbusy = 0;
        gsel = -1;

        @(negedge clk);
        s_awvalid = req;
        s_wvalid  = N'($urandom) | (early_w ? req : '0);
        s_wlast   = N'($urandom);
        s_bready  = N'($urandom);
        m_awready = 1'($urandom); m_wready = 1'($urandom); m_bvalid = 1'($urandom);
        #1 chk_all("idle", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, last_sel, 1'b0, last_beat);
        nbusy += int'(busy);

        hs = 1'b0;
        for (int t = 0; !hs; t++) begin
            @(negedge clk);
            s_awvalid = req;
            if (bp && t == 0) s_awvalid[w] = 1'b0;
            m_awready = bp ? (t >= 3) : 1'b1;
            s_wvalid  = N'($urandom) | (early_w ? req : '0);
            s_wlast   = N'($urandom);
            s_bready  = N'($urandom);
            m_wready  = 1'($urandom); m_bvalid = 1'($urandom);
            #1 chk_all("addr", s_awvalid[w], N'(m_awready) << w, 1'b0, 1'b0, '0, '0, 1'b0,
                       w, 1'b1, 0);
            nbusy += int'(busy);
            if (t == 0) gsel = int'(sel);
            hs = s_awvalid[w] & m_awready;
        end

        k = 0;
        for (int t = 0; k < beats; t++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst = 1'b1;
                s_awvalid = '1; s_wvalid = '1; s_wlast = '1; s_bready = '1;
                m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
                #1 chk_all("midrst", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0, 0);
                @(negedge clk);
                clear_inputs();
                rst = 1'b0;
                ptr_m = 0; last_sel = 0; last_beat = 0;
                return;
            end
            s_awvalid   = req;
            s_wvalid    = N'($urandom);
            s_wlast     = N'($urandom);
            s_wvalid[w] = bp ? (t % 4 != 2) : 1'b1;
            s_wlast[w]  = (k == beats - 1);
            m_wready    = bp ? (t % 2 == 0) : 1'b1;
            m_awready   = 1'($urandom); m_bvalid = 1'($urandom);
            s_bready    = N'($urandom);
            #1 chk_all("data", 1'b0, '0, s_wvalid[w], s_wlast[w], N'(m_wready) << w, '0, 1'b0,
                       w, 1'b1, sat(k));
            nbusy += int'(busy);
            if (s_wvalid[w] && m_wready) k++;
        end

        hs = 1'b0;
        for (int t = 0; !hs; t++) begin
            @(negedge clk);
            s_awvalid   = req;
            s_wvalid    = N'($urandom);
            s_wlast     = N'($urandom);
            s_bready    = N'($urandom);
            s_bready[w] = bp ? (t >= 5) : 1'b1;
            m_bvalid    = bp ? (t >= 5) : 1'b1;
            m_awready   = 1'($urandom); m_wready = 1'($urandom);
            #1 chk_all("resp", 1'b0, '0, 1'b0, 1'b0, '0, N'(m_bvalid) << w, s_bready[w],
                       w, 1'b1, sat(beats));
            nbusy += int'(busy);
            hs = m_bvalid & s_bready[w];
        end
        last_sel  = w;
        last_beat = sat(beats);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, g;
        int win[$];
        rst = 1'b1;
        clear_inputs();

        // Single 1-beat transaction on master 0: busy for ADDR, DATA, RESP only.
        do_reset();
        do_txn(4'b0001, 1, 1'b0, 1'b0, -1, nb, g);
        chk("min_txn busy cycles", 16'(nb), 16'd3);
        chk("min_txn grant", 16'(g), 16'd0);

        // Masters 0 and 1 requesting continuously: strict alternation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(4'b0011, 2, 1'b0, 1'b0, -1, nb, g);
            chk("alt grant", 16'(g), 16'(i % 2));
        end

        // Grant to 1 moves ptr to 2; then 3 wins before 1, master 0 never.
        do_reset();
        do_txn(4'b0010, 1, 1'b0, 1'b0, -1, nb, g);
        chk("ptr grant a", 16'(g), 16'd1);
        do_txn(4'b1010, 1, 1'b0, 1'b0, -1, nb, g);
        chk("ptr grant b", 16'(g), 16'd3);
        do_txn(4'b1010, 1, 1'b0, 1'b0, -1, nb, g);
        chk("ptr grant c", 16'(g), 16'd1);

        // Backpressured 4-beat burst on master 2.
        do_txn(4'b0100, 4, 1'b1, 1'b0, -1, nb, g);
        chk("bp grant", 16'(g), 16'd2);

        // Master 1 presents W before its AW is accepted.
        do_txn(4'b0010, 1, 1'b0, 1'b1, -1, nb, g);
        chk("early_w grant", 16'(g), 16'd1);

        // Reset after 2 of 4 beats, then a fresh grant goes to the lowest requester.
        do_txn(4'b0001, 4, 1'b0, 1'b0, 2, nb, g);
        do_txn(4'b1001, 1, 1'b0, 1'b0, -1, nb, g);
        chk("post_rst grant", 16'(g), 16'd0);

        // Beat counter saturation.
        do_txn(4'b1000, 515, 1'b0, 1'b0, -1, nb, g);
        chk("sat grant", 16'(g), 16'd3);

        // All masters requesting: every window of N grants covers each master once.
        for (int i = 0; i < 2 * N; i++) begin
            do_txn(4'b1111, int'($urandom_range(1, 3)), 1'($urandom), 1'b0, -1, nb, g);
            win.push_back(g);
        end
        for (int i = 0; i + N <= win.size(); i++) begin
            int mask;
            mask = 0;
            for (int j = 0; j < N; j++) mask |= (1 << win[i + j]);
            chk("fair window", 16'(mask), 16'hf);
        end

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] req;
            req = N'($urandom_range(1, 15));
            do_txn(req, int'($urandom_range(1, 5)), 1'($urandom), 1'($urandom), -1, nb, g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
